// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Opcode constants, FSM state encoding and opcode helpers
//                shared by the ALU control unit and its datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [3:0] c_op_and   = 4'b0000;
    localparam logic [3:0] c_op_or    = 4'b0001;
    localparam logic [3:0] c_op_add   = 4'b0010;
    localparam logic [3:0] c_op_sub   = 4'b0110;
    localparam logic [3:0] c_op_slt   = 4'b0111;
    localparam logic [3:0] c_op_nor   = 4'b1100;
    localparam logic [3:0] c_op_mult  = 4'b1000;
    localparam logic [3:0] c_op_multu = 4'b1001;
    localparam logic [3:0] c_op_div   = 4'b1010;
    localparam logic [3:0] c_op_divu  = 4'b1011;
    localparam logic [3:0] c_op_mfhi  = 4'b1101;
    localparam logic [3:0] c_op_mflo  = 4'b1110;

    typedef enum logic [1:0] {
        c_st_idle = 2'd0,
        c_st_busy = 2'd1,
        c_st_done = 2'd2
    } state_t;

    // Mul/div opcodes share 10xx: bit 1 selects divide, bit 0 selects unsigned.
    function automatic logic is_muldiv(input logic [3:0] op);
        return (op[3:2] == 2'b10);
    endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_iter.sv
// ============================================================================
//  Module      : muldiv_iter
//  Description : Iterative shift-add multiplier / restoring divider working on
//                operand magnitudes, one bit per cycle, with final sign fix-up.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             step,
    input  logic             is_div,
    input  logic             is_unsigned,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int c_cnt_w = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_dividend;
    logic               r_is_div;
    logic               r_dz;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_shift;
    logic [WIDTH-1:0]   w_sub;
    logic               w_fit;
    logic [WIDTH-1:0]   w_nhi;
    logic [WIDTH-1:0]   w_nlo;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_a_neg = !is_unsigned && a[WIDTH-1];
    assign w_b_neg = !is_unsigned && b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    // Multiply: {r_hi, r_lo} shifts right, adding the multiplicand into the top half.
    assign w_mul_sum = {1'b0, r_hi} + {1'b0, (r_lo[0] ? r_opnd : {WIDTH{1'b0}})};

    // Divide: r_hi is the partial remainder, r_lo shifts dividend out and quotient in.
    // When the trial fits, the true difference is below the divisor, so the low
    // WIDTH bits of the subtraction are exact.
    assign w_shift = {r_hi, r_lo[WIDTH-1]};
    assign w_fit   = (w_shift >= {1'b0, r_opnd});
    assign w_sub   = w_shift[WIDTH-1:0] - r_opnd;

    always_comb begin
        if (r_is_div) begin
            w_nhi = w_fit ? w_sub : w_shift[WIDTH-1:0];
            w_nlo = {r_lo[WIDTH-2:0], w_fit};
        end else begin
            w_nhi = w_mul_sum[WIDTH:1];
            w_nlo = {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
    end

    assign w_prod = r_neg_q ? -{w_nhi, w_nlo} : {w_nhi, w_nlo};
    assign w_quo  = r_dz ? {WIDTH{1'b1}} : (r_neg_q ? -w_nlo : w_nlo);
    assign w_rem  = r_dz ? r_dividend    : (r_neg_r ? -w_nhi : w_nhi);

    assign hi_out = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    assign lo_out = r_is_div ? w_quo : w_prod[WIDTH-1:0];
    assign done   = step && (r_cnt == c_cnt_w'(WIDTH - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_opnd     <= '0;
            r_dividend <= '0;
            r_is_div   <= 1'b0;
            r_dz       <= 1'b0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_cnt      <= '0;
        end else if (start) begin
            r_hi       <= '0;
            r_lo       <= w_a_mag;
            r_opnd     <= w_b_mag;
            r_dividend <= a;
            r_is_div   <= is_div;
            r_dz       <= is_div && (b == '0);
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_cnt      <= '0;
        end else if (step) begin
            r_hi  <= w_nhi;
            r_lo  <= w_nlo;
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_muldiv.sv
// ============================================================================
//  Module      : alu_muldiv
//  Description : Handshaked ALU with single-cycle logic/arith ops, HI/LO
//                registers and an iterative multiply/divide unit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [3:0]       ALUControl,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             zero,
    output logic             overflow
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;

    logic             w_accept;
    logic             w_is_md;
    logic             w_start;
    logic             w_step;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_hi;
    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] w_alu;
    logic             w_ovf;

    assign w_accept = in_valid && (r_state == c_st_idle);
    assign w_is_md  = is_muldiv(ALUControl);
    assign w_start  = w_accept && w_is_md;
    assign w_step   = (r_state == c_st_busy);

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv_iter (
        .clk        (clk),
        .reset      (reset),
        .start      (w_start),
        .step       (w_step),
        .is_div     (ALUControl[1]),
        .is_unsigned(ALUControl[0]),
        .a          (data1),
        .b          (data2),
        .done       (w_md_done),
        .hi_out     (w_md_hi),
        .lo_out     (w_md_lo)
    );

    assign w_sum  = data1 + data2;
    assign w_diff = data1 - data2;

    always_comb begin
        w_alu = '0;
        w_ovf = 1'b0;
        case (ALUControl)
            c_op_and:  w_alu = data1 & data2;
            c_op_or:   w_alu = data1 | data2;
            c_op_nor:  w_alu = ~(data1 | data2);
            c_op_add: begin
                w_alu = w_sum;
                w_ovf = (data1[WIDTH-1] == data2[WIDTH-1]) && (w_sum[WIDTH-1] != data1[WIDTH-1]);
            end
            c_op_sub: begin
                w_alu = w_diff;
                w_ovf = (data1[WIDTH-1] != data2[WIDTH-1]) && (w_diff[WIDTH-1] != data1[WIDTH-1]);
            end
            c_op_slt:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
            c_op_mfhi: w_alu = r_hi;
            c_op_mflo: w_alu = r_lo;
            default:   w_alu = '0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_idle: if (w_accept) w_state_nxt = w_is_md ? c_st_busy : c_st_done;
            c_st_busy: if (w_md_done) w_state_nxt = c_st_done;
            c_st_done: if (out_ready) w_state_nxt = c_st_idle;
            default:   w_state_nxt = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Result registers only load on acceptance or mul/div completion, so they hold in DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept && !w_is_md) begin
            r_result <= w_alu;
            r_zero   <= (w_alu == '0);
            r_ovf    <= w_ovf;
        end else if (w_md_done) begin
            r_hi     <= w_md_hi;
            r_lo     <= w_md_lo;
            r_result <= w_md_lo;
            r_zero   <= (w_md_lo == '0);
            r_ovf    <= 1'b0;
        end
    end

    assign in_ready  = (r_state == c_st_idle);
    assign out_valid = (r_state == c_st_done);
    assign ALUResult = r_result;
    assign zero      = r_zero;
    assign overflow  = r_ovf;

endmodule

`default_nettype wire

// File: doc/alu_muldiv.md
ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand/result width in bits (legal range 8..64, even).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have ports data1 and data2, input, WIDTH, the operands; signed or unsigned per opcode.
REQ-005 SHALL have port ALUControl, input, 4, the opcode.
REQ-006 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the operand handshake.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the result handshake.
REQ-008 SHALL have port ALUResult, output, WIDTH, the registered result.
REQ-009 SHALL have ports zero (output, 1, ALUResult==0) and overflow (output, 1, signed ADD/SUB overflow, else 0).

Function
REQ-010 SHALL decode opcodes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100, MULT 1000, MULTU 1001, DIV 1010, DIVU 1011, MFHI 1101, MFLO 1110; any other opcode gives result 0, overflow 0, and leaves HI/LO unchanged.
REQ-011 SHALL accept an operation on a rising edge where in_valid && in_ready; in_ready SHALL be 1 only in state IDLE.
REQ-012 SHALL implement states IDLE, BUSY, DONE: IDLE->DONE on accepting a single-cycle op; IDLE->BUSY on accepting MULT/MULTU/DIV/DIVU; BUSY->DONE when the iteration counter reaches WIDTH; DONE->IDLE on the edge where out_ready is 1.
REQ-013 SHALL assert out_valid exactly while in DONE; ALUResult, zero, and overflow SHALL stay stable while out_valid && !out_ready.
REQ-014 SHALL produce single-cycle ops with latency 1: accepted at edge N -> out_valid high after edge N.
REQ-015 SHALL compute ADD/SUB modulo 2^WIDTH and set overflow when operand signs match (ADD) or differ (SUB) and the result sign differs from data1.
REQ-016 SHALL make SLT a signed compare, result 1 or 0.
REQ-017 SHALL make MULT/MULTU shift-add, one partial product per cycle; exactly WIDTH cycles in BUSY; {HI,LO} = full 2*WIDTH product, signed or unsigned.
REQ-018 SHALL make DIV/DIVU restoring division, one quotient bit per cycle, WIDTH cycles; LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-019 SHALL handle divisor 0 as: LO = all ones, HI = dividend, no exception, same latency.
REQ-020 SHALL handle DIV of most-negative by -1 as: LO = most-negative, HI = 0.
REQ-021 SHALL set ALUResult to the new LO for MULT/MULTU/DIV/DIVU, and to current HI/LO for MFHI/MFLO.
REQ-022 SHALL update HI/LO only on completion of a mul/div.
REQ-023 SHALL ignore in_valid while BUSY or DONE; the operands are captured at acceptance, so input changes afterwards have no effect.

Reset
REQ-024 SHALL, on reset asserted at any time including mid-BUSY, force state IDLE, abort any operation, and clear HI, LO, the counter, ALUResult, zero, overflow, and out_valid to 0; in_ready SHALL be 1 once reset deasserts.
REQ-025 SHALL treat reset asynchronously on assertion; the first operation may be accepted on the first clk edge after deassertion.

Structure
REQ-026 SHALL place the opcode constants and the state encoding in a shared package alu_pkg, reused by the control unit.
REQ-027 SHALL use one sub-module, muldiv_iter, holding the iterative multiply/divide datapath and counter; alu_muldiv holds the single-cycle logic, HI/LO, and the FSM.

Verification
REQ-028 SHALL cover: WIDTH=32, ADD 0x7FFFFFFF+1 -> ALUResult 0x80000000, overflow 1, zero 0, out_valid one cycle after acceptance.
REQ-029 SHALL cover: SUB 5-5 -> ALUResult 0, zero 1; SLT -1,1 -> 1.
REQ-030 SHALL cover: MULT -3 x 7 -> out_valid 32 cycles after entering BUSY, HI 0xFFFFFFFF, LO 0xFFFFFFEB; then MFHI -> 0xFFFFFFFF.
REQ-031 SHALL cover: DIV -7/2 -> LO 0xFFFFFFFD, HI 0xFFFFFFFF; DIVU 10/0 -> LO 0xFFFFFFFF, HI 10.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles after ADD 1+2 -> ALUResult stays 3, in_ready stays 0, a new in_valid is ignored.
REQ-033 SHALL cover: reset pulse at cycle 10 of MULTU -> out_valid 0, HI/LO 0, in_ready 1 after release; a following ADD 2+2 -> 4.
